// File: rtl/sc_pkg.sv
// rtl/sc_pkg.sv - shared stochastic-computing types and widths for sng / sbs_decoder
package sc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } sbs_dec_state_t;

    localparam int SC_N_BITS = 8;
    localparam int SC_LEN    = 255;

endpackage

// File: rtl/sbs_popcount.sv
// rtl/sbs_popcount.sv - combinational ones-count of a LANES-bit slice
module sbs_popcount #(
    parameter int LANES = 1
) (
    input  logic [LANES-1:0]           bits_i,
    output logic [$clog2(LANES+1)-1:0] count_o
);

    localparam int CW = $clog2(LANES + 1);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < LANES; i++) begin
            count_o = count_o + CW'(bits_i[i]);
        end
    end

endmodule

// File: rtl/sbs_decoder.sv
// rtl/sbs_decoder.sv - stochastic bitstream to binary converter; SBS_DEC_BIPOLAR_EN selects bipolar output
module sbs_decoder
    import sc_pkg::*;
#(
    parameter int N_BITS = SC_N_BITS,
    parameter int LEN    = SC_LEN,
    parameter int LANES  = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [LEN-1:0]    sbs_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [N_BITS:0]   result_o
);

    localparam int BEATS = LEN / LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PCW   = $clog2(LANES + 1);

    sbs_dec_state_t    state_q, state_d;
    logic [LEN-1:0]    shreg_q, shreg_d;
    logic [N_BITS-1:0] count_q, count_d, sum;
    logic [BW-1:0]     beat_q, beat_d;
    logic [N_BITS:0]   result_q, result_d;
    logic [PCW-1:0]    pop;
    logic              accept, last_beat;

    // Unipolar: ones count. Bipolar: 2*count - LEN in two's complement.
    function automatic logic [N_BITS:0] fmt(input logic [N_BITS-1:0] c);
`ifdef SBS_DEC_BIPOLAR_EN
        return {c, 1'b0} - (N_BITS+1)'(LEN);
`else
        return {1'b0, c};
`endif
    endfunction

    sbs_popcount #(.LANES(LANES)) u_popcount (
        .bits_i  (shreg_q[LANES-1:0]),
        .count_o (pop)
    );

    assign sum       = count_q + N_BITS'(pop);
    assign last_beat = (beat_q == BW'(BEATS - 1));
    assign accept    = start_i && (state_q != COUNT);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            count_q  <= '0;
            beat_q   <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            count_q  <= count_d;
            beat_q   <= beat_d;
            result_q <= result_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i)   state_d = COUNT;
            COUNT:   if (last_beat) state_d = DONE;
            DONE:    if (start_i)   state_d = COUNT;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d  = shreg_q;
        count_d  = count_q;
        beat_d   = beat_q;
        result_d = result_q;
        if (accept) begin
            shreg_d = sbs_i;
            count_d = '0;
            beat_d  = '0;
        end else if (state_q == COUNT) begin
            shreg_d = shreg_q >> LANES;
            count_d = sum;
            beat_d  = beat_q + 1'b1;
            if (last_beat) begin
                result_d = fmt(sum);
            end
        end
    end

    always_comb begin
        busy_o   = (state_q == COUNT);
        done_o   = (state_q == DONE);
        result_o = result_q;
    end

endmodule
